// File: rtl/ray_aabb_sched_if.sv
// Job/result/datapath bundle for the ray-AABB test scheduler.
// The scheduler uses the slave view; the surrounding environment (job source,
// result sink and the ray-box datapath) uses the master view.
interface ray_aabb_sched_if #(
   parameter int W     = 17,
   parameter int TAG_W = 8
) ();
   // job channel
   logic             in_valid;
   logic             in_ready;
   logic [TAG_W-1:0] in_tag;
   logic             in_exp;
   logic [6*W-1:0]   in_box;
   logic [3*W-1:0]   in_org;
   logic [3*W-1:0]   in_div;
   logic [2:0]       in_dir;
   // datapath operands and returned result
   logic [6*W-1:0]   dp_box;
   logic [3*W-1:0]   dp_org;
   logic [3*W-1:0]   dp_div;
   logic [2:0]       dp_dir;
   logic             dp_hit;
   // result channel
   logic             out_valid;
   logic             out_ready;
   logic [TAG_W-1:0] out_tag;
   logic             out_hit;
   logic             out_err;

   modport slave (
      input  in_valid, in_tag, in_exp, in_box, in_org, in_div, in_dir,
      output in_ready,
      output dp_box, dp_org, dp_div, dp_dir,
      input  dp_hit,
      output out_valid, out_tag, out_hit, out_err,
      input  out_ready
   );

   modport master (
      output in_valid, in_tag, in_exp, in_box, in_org, in_div, in_dir,
      input  in_ready,
      input  dp_box, dp_org, dp_div, dp_dir,
      output dp_hit,
      input  out_valid, out_tag, out_hit, out_err,
      output out_ready
   );
endinterface

// File: rtl/ray_aabb_sched.sv
// Ray-AABB job scheduler: issues jobs to a fixed-latency datapath, tracks
// them in a tag/expectation delay line, and buffers results in a credit-
// protected FIFO so the datapath never has to stall.
module ray_aabb_sched #(
   parameter int W     = 17,
   parameter int LAT   = 34,
   parameter int TAG_W = 8,
   parameter int DEPTH = 64
) (
   input  logic            clk,
   input  logic            rst,
   ray_aabb_sched_if.slave bus,
   input  logic            flush,
   output logic            done,
   output logic            busy,
   output logic [15:0]     type1_cnt,
   output logic [15:0]     type2_cnt
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = TAG_W + 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [CW-1:0] CNT_ZERO = CW'(0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW:0]   DEPTH_W  = (CW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [15:0]   SAT_MAX  = 16'hFFFF;

   // Advance a FIFO pointer, wrapping modulo DEPTH.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      logic [AW-1:0] r;
      if (p == PTR_LAST) begin
         r = '0;
      end else begin
         r = p + PTR_ONE;
      end
      return r;
   endfunction

   // Increment a 16-bit event counter, sticking at all-ones.
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      logic [15:0] r;
      if (v == SAT_MAX) begin
         r = v;
      end else begin
         r = v + 16'd1;
      end
      return r;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    inflight_q, inflight_d;
   logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [EW-1:0]    head_q, head_d;
   logic [LAT:0]     dl_vld_q, dl_vld_d;
   logic [LAT:0]     dl_exp_q, dl_exp_d;
   logic [TAG_W-1:0] dl_tag_q [LAT+1];
   logic [TAG_W-1:0] dl_tag_d [LAT+1];
   logic [6*W-1:0]   dp_box_q, dp_box_d;
   logic [3*W-1:0]   dp_org_q, dp_org_d;
   logic [3*W-1:0]   dp_div_q, dp_div_d;
   logic [2:0]       dp_dir_q, dp_dir_d;
   logic             done_q, done_d;
   logic [15:0]      t1_q, t1_d;
   logic [15:0]      t2_q, t2_d;

   logic             in_ready_s;
   logic             accept_s;
   logic             retire_s;
   logic             pop_s;
   logic             fifo_empty_s;
   logic [CW:0]      credit_used_s;
   logic [EW-1:0]    wdata_s;

   // Handshake qualifiers; in_ready depends only on registered state and rst.
   always_comb begin
      credit_used_s = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
      in_ready_s    = (state_q != ST_DRAIN) && !rst && (credit_used_s < DEPTH_W);
      accept_s      = bus.in_valid && in_ready_s;
      retire_s      = dl_vld_q[LAT];
      fifo_empty_s  = (fifo_cnt_q == CNT_ZERO);
      pop_s         = bus.out_ready && !fifo_empty_s;
      wdata_s       = {dl_tag_q[LAT], bus.dp_hit, bus.dp_hit ^ dl_exp_q[LAT]};
   end

   // Operand registers load on issue and otherwise hold for the datapath.
   always_comb begin
      if (accept_s) begin
         dp_box_d = bus.in_box;
         dp_org_d = bus.in_org;
         dp_div_d = bus.in_div;
         dp_dir_d = bus.in_dir;
      end else begin
         dp_box_d = dp_box_q;
         dp_org_d = dp_org_q;
         dp_div_d = dp_div_q;
         dp_dir_d = dp_dir_q;
      end
   end

   // Delay line shadowing the datapath; the last stage lines up with dp_hit.
   always_comb begin
      dl_vld_d    = '0;
      dl_exp_d    = '0;
      dl_tag_d    = dl_tag_q;
      dl_vld_d[0] = accept_s;
      dl_exp_d[0] = bus.in_exp;
      dl_tag_d[0] = bus.in_tag;
      for (int k = 1; k <= LAT; k++) begin
         dl_vld_d[k] = dl_vld_q[k-1];
         dl_exp_d[k] = dl_exp_q[k-1];
         dl_tag_d[k] = dl_tag_q[k-1];
      end
   end

   // In-flight and FIFO occupancy plus pointer movement.
   always_comb begin
      case ({accept_s, retire_s})
         2'b10:   inflight_d = inflight_q + CNT_ONE;
         2'b01:   inflight_d = inflight_q - CNT_ONE;
         default: inflight_d = inflight_q;
      endcase
      case ({retire_s, pop_s})
         2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
         2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase
      if (retire_s) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
   end

   // Head register always mirrors the oldest stored entry; a write into an
   // empty FIFO becomes visible one edge later (no bypass).
   always_comb begin
      head_d = head_q;
      if (fifo_empty_s) begin
         if (retire_s) begin
            head_d = wdata_s;
         end else begin
            head_d = head_q;
         end
      end else if (pop_s) begin
         if (fifo_cnt_q == CNT_ONE) begin
            if (retire_s) begin
               head_d = wdata_s;
            end else begin
               head_d = head_q;
            end
         end else begin
            head_d = mem_q[ptr_inc(rd_ptr_q)];
         end
      end else begin
         head_d = head_q;
      end
   end

   // Mismatch counters: type1 = expected hit but missed, type2 = the reverse.
   always_comb begin
      t1_d = t1_q;
      t2_d = t2_q;
      if (retire_s) begin
         if (dl_exp_q[LAT] && !bus.dp_hit) begin
            t1_d = sat_inc(t1_q);
         end else begin
            t1_d = t1_q;
         end
         if (!dl_exp_q[LAT] && bus.dp_hit) begin
            t2_d = sat_inc(t2_q);
         end else begin
            t2_d = t2_q;
         end
      end else begin
         t1_d = t1_q;
         t2_d = t2_q;
      end
   end

   // Control FSM; flush wins over a concurrent issue, drain completion pulses done.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (flush) begin
               state_d = ST_DRAIN;
            end else if (accept_s) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (flush) begin
               state_d = ST_DRAIN;
            end else if (!accept_s && (inflight_q == CNT_ZERO) && fifo_empty_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if ((inflight_q == CNT_ZERO) && fifo_empty_s) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
         end
      endcase
   end

   // Control, tracking and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         inflight_q <= CNT_ZERO;
         fifo_cnt_q <= CNT_ZERO;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         head_q     <= '0;
         dl_vld_q   <= '0;
         dl_exp_q   <= '0;
         dl_tag_q   <= '{default: '0};
         dp_box_q   <= '0;
         dp_org_q   <= '0;
         dp_div_q   <= '0;
         dp_dir_q   <= 3'b000;
         done_q     <= 1'b0;
         t1_q       <= 16'h0000;
         t2_q       <= 16'h0000;
      end else begin
         state_q    <= state_d;
         inflight_q <= inflight_d;
         fifo_cnt_q <= fifo_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         head_q     <= head_d;
         dl_vld_q   <= dl_vld_d;
         dl_exp_q   <= dl_exp_d;
         dl_tag_q   <= dl_tag_d;
         dp_box_q   <= dp_box_d;
         dp_org_q   <= dp_org_d;
         dp_div_q   <= dp_div_d;
         dp_dir_q   <= dp_dir_d;
         done_q     <= done_d;
         t1_q       <= t1_d;
         t2_q       <= t2_d;
      end
   end

   // Result storage; contents are don't-care until written, pointers guard reads.
   always_ff @(posedge clk) begin
      if (!rst && retire_s) begin
         mem_q[wr_ptr_q] <= wdata_s;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.dp_box    = dp_box_q;
   assign bus.dp_org    = dp_org_q;
   assign bus.dp_div    = dp_div_q;
   assign bus.dp_dir    = dp_dir_q;
   assign bus.out_valid = !fifo_empty_s;
   assign bus.out_tag   = head_q[EW-1:2];
   assign bus.out_hit   = head_q[1];
   assign bus.out_err   = head_q[0];
   assign done          = done_q;
   assign busy          = (state_q != ST_IDLE);
   assign type1_cnt     = t1_q;
   assign type2_cnt     = t2_q;

endmodule

// File: tb/tb_ray_aabb_sched.sv
// Directed bench for ray_aabb_sched. The datapath stand-in is a LAT-deep
// pipeline that returns bit 0 of dp_box, so each job's hit is chosen by
// the lsb of its in_box.
module tb_ray_aabb_sched;
   localparam int W     = 17;
   localparam int LAT   = 34;
   localparam int TAG_W = 8;
   localparam int DEPTH = 64;

   logic           clk;
   logic           rst;
   logic           flush;
   logic           done;
   logic           busy;
   logic [15:0]    type1_cnt;
   logic [15:0]    type2_cnt;
   logic [LAT-1:0] pipe_q;

   int nvec = 0;
   int nerr = 0;

   ray_aabb_sched_if #(.W(W), .TAG_W(TAG_W)) bus_if ();

   ray_aabb_sched #(.W(W), .LAT(LAT), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus_if),
      .flush     (flush),
      .done      (done),
      .busy      (busy),
      .type1_cnt (type1_cnt),
      .type2_cnt (type2_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Fixed-latency datapath stand-in.
   always_ff @(posedge clk) pipe_q <= {pipe_q[LAT-2:0], bus_if.dp_box[0]};
   assign bus_if.dp_hit = pipe_q[LAT-1];

   // Hang guard.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_box(input string tag, input logic [6*W-1:0] obs, input logic [6*W-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_job(input logic [7:0] tag, input logic exp, input logic hit, input int seed);
      bus_if.in_valid = 1'b1;
      bus_if.in_tag   = tag;
      bus_if.in_exp   = exp;
      bus_if.in_box   = {(6*W-1)'(seed), hit};
      bus_if.in_org   = (3*W)'(seed * 3);
      bus_if.in_div   = (3*W)'(seed * 5 + 1);
      bus_if.in_dir   = 3'(seed);
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 100 && busy; c++) tick();
      chk("idle_busy", int'(busy), 0);
   endtask

   // Back-to-back issue with out_ready=1; results checked as they stream out.
   task automatic burst(input int n, input logic [127:0] hits, input logic [127:0] exps,
                        input logic [7:0] tag0);
      int got;
      int first;
      int last;
      logic [7:0] t;
      got   = 0;
      first = -1;
      last  = -1;
      bus_if.out_ready = 1'b1;
      for (int c = 0; c < n + 80 && got < n; c++) begin
         if (c < n) begin
            t = tag0 + 8'(c);
            drive_job(t, exps[c], hits[c], c);
            chk("burst_in_ready", int'(bus_if.in_ready), 1);
         end else begin
            bus_if.in_valid = 1'b0;
         end
         if (bus_if.out_valid) begin
            t = tag0 + 8'(got);
            chk("burst_tag", int'(bus_if.out_tag), int'(t));
            chk("burst_hit", int'(bus_if.out_hit), int'(hits[got]));
            chk("burst_err", int'(bus_if.out_err), int'(hits[got] ^ exps[got]));
            if (first < 0) first = c;
            last = c;
            got++;
         end
         tick();
      end
      bus_if.in_valid = 1'b0;
      chk("burst_count", got, n);
      // job 0 accepted at the edge after sample 0, visible 35 edges later
      chk("burst_first", first, 36);
      chk("burst_span", last - first, n - 1);
   endtask

   initial begin
      logic [6*W-1:0] jb;
      logic [127:0]   h;
      logic [127:0]   e;
      int n;
      int acc;
      int pops;
      int dones;
      int done_c;
      int last_pop;
      int seen;
      logic [7:0] exp_t;

      rst              = 1'b1;
      flush            = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.in_tag    = '0;
      bus_if.in_exp    = 1'b0;
      bus_if.in_box    = '0;
      bus_if.in_org    = '0;
      bus_if.in_div    = '0;
      bus_if.in_dir    = 3'b000;
      bus_if.out_ready = 1'b0;

      // ---- reset state
      repeat (3) tick();
      chk("rst_in_ready", int'(bus_if.in_ready), 0);
      chk("rst_out_valid", int'(bus_if.out_valid), 0);
      chk("rst_out_tag", int'(bus_if.out_tag), 0);
      chk("rst_out_hit", int'(bus_if.out_hit), 0);
      chk("rst_out_err", int'(bus_if.out_err), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_type1", int'(type1_cnt), 0);
      chk("rst_type2", int'(type2_cnt), 0);
      chk_box("rst_dp_box", bus_if.dp_box, '0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", int'(bus_if.in_ready), 1);

      // ---- single job: tag 5, exp 1, hit 1
      drive_job(8'd5, 1'b1, 1'b1, 7);
      jb = bus_if.in_box;
      tick();
      bus_if.in_valid = 1'b0;
      bus_if.in_box   = '1;
      chk_box("single_dp_load", bus_if.dp_box, jb);
      chk("single_busy", int'(busy), 1);
      tick();
      n = 1;
      chk_box("single_dp_hold", bus_if.dp_box, jb);
      while (!bus_if.out_valid && n < 100) begin
         tick();
         n++;
      end
      chk("single_latency", n, 35);
      chk("single_tag", int'(bus_if.out_tag), 5);
      chk("single_hit", int'(bus_if.out_hit), 1);
      chk("single_err", int'(bus_if.out_err), 0);
      chk("single_type1", int'(type1_cnt), 0);
      chk("single_type2", int'(type2_cnt), 0);
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
      chk("single_popped", int'(bus_if.out_valid), 0);
      wait_idle();

      // ---- 100 back-to-back jobs, no mismatches
      h = 128'hA5A5_3C3C_0FF0_1234_5678_9ABC_DEF0_1357;
      e = h;
      burst(100, h, e, 8'd0);
      chk("b2b_type1", int'(type1_cnt), 0);
      chk("b2b_type2", int'(type2_cnt), 0);
      wait_idle();

      // ---- backpressure: 70 offered, 64 credits
      bus_if.out_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 70; c++) begin
         drive_job(8'(acc), 1'b0, 1'b0, c);
         if (bus_if.in_ready) acc++;
         tick();
      end
      bus_if.in_valid = 1'b0;
      chk("bp_accepted", acc, 64);
      chk("bp_ready_low", int'(bus_if.in_ready), 0);
      repeat (40) tick();
      chk("bp_full_valid", int'(bus_if.out_valid), 1);
      chk("bp_head", int'(bus_if.out_tag), 0);
      chk("bp_still_low", int'(bus_if.in_ready), 0);
      bus_if.out_ready = 1'b1;
      tick();
      bus_if.out_ready = 1'b0;
      chk("bp_ready_after_pop", int'(bus_if.in_ready), 1);
      chk("bp_head_next", int'(bus_if.out_tag), 1);
      acc = 0;
      for (int c = 0; c < 3; c++) begin
         drive_job(8'd64, 1'b0, 1'b0, 100 + c);
         if (bus_if.in_ready) acc++;
         tick();
      end
      bus_if.in_valid = 1'b0;
      chk("bp_one_more", acc, 1);
      repeat (40) tick();
      bus_if.out_ready = 1'b1;
      pops  = 0;
      exp_t = 8'd1;
      for (int c = 0; c < 100 && pops < 64; c++) begin
         if (bus_if.out_valid) begin
            chk("bp_order", int'(bus_if.out_tag), int'(exp_t));
            exp_t = exp_t + 8'd1;
            pops++;
         end
         tick();
      end
      bus_if.out_ready = 1'b0;
      chk("bp_drain", pops, 64);
      wait_idle();

      // ---- mismatch patterns: (hit,exp) = (0,1)x3, (1,0)x2, (1,1), (0,0)
      h = 128'h38;
      e = 128'h27;
      burst(7, h, e, 8'h40);
      chk("mm_type1", int'(type1_cnt), 3);
      chk("mm_type2", int'(type2_cnt), 2);
      wait_idle();

      // ---- flush with 10 jobs in flight
      bus_if.out_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
         drive_job(8'(200 + c), 1'b0, 1'b0, c);
         chk("fl_in_ready", int'(bus_if.in_ready), 1);
         tick();
      end
      bus_if.in_valid = 1'b0;
      flush = 1'b1;
      tick();
      chk("fl_ready_low", int'(bus_if.in_ready), 0);
      chk("fl_busy", int'(busy), 1);
      drive_job(8'd99, 1'b0, 1'b0, 99);
      repeat (4) tick();
      flush = 1'b0;
      repeat (40) tick();
      chk("fl_ready_still_low", int'(bus_if.in_ready), 0);
      chk("fl_out_valid", int'(bus_if.out_valid), 1);
      bus_if.in_valid  = 1'b0;
      bus_if.out_ready = 1'b1;
      pops     = 0;
      dones    = 0;
      done_c   = -1;
      last_pop = -1;
      for (int c = 0; c < 60; c++) begin
         if (bus_if.out_valid) begin
            chk("fl_order", int'(bus_if.out_tag), 200 + pops);
            pops++;
            last_pop = c;
         end
         if (done) begin
            dones++;
            done_c = c;
         end
         tick();
      end
      bus_if.out_ready = 1'b0;
      chk("fl_pops", pops, 10);
      chk("fl_done_once", dones, 1);
      chk("fl_done_after_pop", int'(done_c > last_pop), 1);
      chk("fl_idle", int'(busy), 0);
      chk("fl_ready_back", int'(bus_if.in_ready), 1);

      // ---- reset with 20 jobs in flight (all would count as type2)
      bus_if.out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         drive_job(8'(c), 1'b0, 1'b1, c);
         tick();
      end
      bus_if.in_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_ready_low", int'(bus_if.in_ready), 0);
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_ready", int'(bus_if.in_ready), 1);
      chk("mid_rst_valid", int'(bus_if.out_valid), 0);
      chk("mid_rst_busy", int'(busy), 0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (bus_if.out_valid) seen++;
         tick();
      end
      chk("mid_rst_no_result", seen, 0);
      chk("mid_rst_type2", int'(type2_cnt), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/ray_aabb_sched.md
RAY_AABB_SCHED -- requirements
Module: ray_aabb_sched

Interface
REQ-001 SHALL have parameter W, default 17: coordinate/reciprocal word width, matching the Ray_AABB_11_3 operand width.
REQ-002 SHALL have parameter LAT, default 34: datapath latency in clock edges from operand presentation to valid dp_hit.
REQ-003 SHALL have parameter TAG_W, default 8: job tag width.
REQ-004 SHALL have parameter DEPTH, default 64 (power of two, >=1): result FIFO depth and total credit count.
REQ-005 SHALL use one clock; reset is synchronous and active-high, with ports named as follows:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  job offered.
- in_ready  out  1  job accepted when in_valid and in_ready are both high at an edge.
- in_tag  in  TAG_W  job identifier.
- in_exp  in  1  expected high-precision hit result.
- in_box  in  6*W  {x0,y0,z0,x1,y1,z1}.
- in_org  in  3*W  {x2,y2,z2}.
- in_div  in  3*W  {divx,divy,divz}.
- in_dir  in  3  {x,y,z} direction signs.
- dp_box  out  6*W  registered copy of in_box, driven to the datapath.
- dp_org  out  3*W  registered copy of in_org, driven to the datapath.
- dp_div  out  3*W  registered copy of in_div, driven to the datapath.
- dp_dir  out  3  registered copy of in_dir, driven to the datapath.
- dp_hit  in  1  hit_miss returned by the datapath.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed when out_valid and out_ready are both high at an edge.
- out_tag  out  TAG_W  tag of the result.
- out_hit  out  1  datapath result.
- out_err  out  1  out_hit != expected value.
- flush  in  1  request to drain the block.
- done  out  1  one-cycle pulse when a drain completes.
- busy  out  1  state != IDLE.
- type1_cnt  out  16  count of results with exp=1 and hit=0.
- type2_cnt  out  16  count of results with exp=0 and hit=1.

Function
REQ-006 SHALL implement states IDLE, RUN, DRAIN:
- IDLE->RUN on an accepted job.
- RUN->IDLE when inflight=0 and the FIFO is empty.
- RUN or IDLE->DRAIN on flush=1.
- DRAIN->IDLE when inflight=0 and the FIFO is empty; done=1 for exactly that cycle.
REQ-007 SHALL drive in_ready = (state!=DRAIN) && !rst && (inflight + fifo_count < DEPTH).
- in_ready SHALL be a function of registered state only; no combinational path from out_ready or in_valid.
REQ-008 On an accepted job at edge E, dp_* SHALL load the job operands at E.
- dp_* SHALL hold their previous values on non-issue cycles.
REQ-009 SHALL keep a LAT+1-stage delay line of {valid, tag, exp}.
- Stage 0 SHALL be loaded at E, with valid=0 on non-issue cycles.
- The entry SHALL retire at edge E+LAT+1, sampling dp_hit at that edge.
REQ-010 On a valid retire, SHALL write {tag, hit, hit^exp} into the FIFO.
- Credit accounting SHALL guarantee the FIFO is never full at a write.
REQ-011 inflight SHALL count accepted-but-unretired jobs.
- Simultaneous issue and retire SHALL leave inflight unchanged.
- Simultaneous FIFO write and pop SHALL leave fifo_count unchanged.
REQ-012 FIFO SHALL be first-word-registered with no bypass.
- out_* SHALL reflect the head entry; out_valid = fifo_count!=0.
- Pointers SHALL wrap modulo DEPTH.
REQ-013 Results SHALL leave in acceptance order.
- Minimum acceptance-to-out_valid latency SHALL be LAT+1 edges.
REQ-014 Sustained throughput SHALL be one job per cycle while out_ready=1.
REQ-015 SHALL update type1_cnt/type2_cnt at each FIFO write according to exp/hit, saturating at 16'hFFFF.
REQ-016 flush asserted during DRAIN SHALL have no effect; in_valid during DRAIN SHALL be ignored.

Reset
REQ-017 While rst=1 at an edge, the block SHALL set:
- state=IDLE, inflight=0, FIFO empty, all delay-line valids=0.
- dp_*=0, out_valid=0, out_tag=0, out_hit=0, out_err=0.
- done=0, busy=0, type1_cnt=0, type2_cnt=0.
REQ-018 Reset mid-operation SHALL discard all in-flight and buffered results.
- dp_hit samples from pre-reset jobs SHALL never be written.
REQ-019 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-020 Single job, tag=5, exp=1, dp_hit model returns 1 -> out_valid rises exactly 35 edges after acceptance with out_tag=5, out_hit=1, out_err=0; counters unchanged.
REQ-021 100 back-to-back jobs, out_ready=1 -> in_ready never drops; 100 results in tag order, one per cycle.
REQ-022 out_ready=0, 70 jobs offered -> exactly 64 accepted, then in_ready=0; after 1 pop, in_ready=1 and exactly one more job is accepted.
REQ-023 Mismatch patterns: exp=1/hit=0 x3 and exp=0/hit=1 x2 -> type1_cnt=3, type2_cnt=2, out_err=1 on those 5 results.
REQ-024 flush with 10 jobs in flight -> in_ready=0 immediately; done pulses once after the 10th result pops; state=IDLE.
REQ-025 rst asserted with 20 jobs in flight -> out_valid=0 and no result appears for the following 40 cycles.
